// File: rtl/inert_intf.sv
// inert_intf: sequences the IMU over an SPI master, then compensates and fuses
// pitch rate with accelerometer pitch into ptch/ptch_rt with a vld strobe.
module inert_intf #(
  parameter bit fast_sim = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET = 16'h00A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        cmd,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               vld
);
  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;
  localparam logic [15:0] TC = fast_sim ? 16'd511 : 16'd65535;
  state_t state, nxt;
  logic [2:0] int_sync;
  logic [15:0] timer;
  logic [7:0] pl, ph, al;
  logic int_rise, upd, unused_bits;
  logic signed [15:0] rate_comp, az_comp, ptch_acc;
  logic signed [24:0] az_ext, prod;
  logic signed [26:0] ptch_int, rate_ext, fusion;
  assign int_rise = int_sync[1] & ~int_sync[2];
  assign upd = (state == RD_AH) && done;
  // AH is taken straight off the bus so the sample updates on the final done
  assign rate_comp = {ph, pl} - PTCH_RT_OFFSET;
  assign az_comp = {rd_data[7:0], al} - AZ_OFFSET;
  assign az_ext = {{9{az_comp[15]}}, az_comp};
  assign prod = az_ext * 25'sd327;
  assign ptch_acc = {{4{prod[24]}}, prod[24:13]};
  assign rate_ext = {{11{rate_comp[15]}}, rate_comp};
  assign fusion = (ptch_acc > ptch) ? 27'sd1024 : -27'sd1024;
  assign ptch = ptch_int[26:11];
  assign unused_bits = ^{rd_data[15:8], prod[12:0]};
  always_comb begin
    nxt = state;
    cmd = 16'h0000;
    case (state)
      INIT_WAIT: nxt = (timer == TC) ? CFG0 : INIT_WAIT;
      CFG0: begin
        cmd = 16'h0D02;
        nxt = done ? CFG1 : CFG0;
      end
      CFG1: begin
        cmd = 16'h1053;
        nxt = done ? CFG2 : CFG1;
      end
      CFG2: begin
        cmd = 16'h1150;
        nxt = done ? CFG3 : CFG2;
      end
      CFG3: begin
        cmd = 16'h1460;
        nxt = done ? IDLE : CFG3;
      end
      IDLE: nxt = int_rise ? RD_PL : IDLE;
      RD_PL: begin
        cmd = 16'hA200;
        nxt = done ? RD_PH : RD_PL;
      end
      RD_PH: begin
        cmd = 16'hA300;
        nxt = done ? RD_AL : RD_PH;
      end
      RD_AL: begin
        cmd = 16'hAC00;
        nxt = done ? RD_AH : RD_AL;
      end
      RD_AH: begin
        cmd = 16'hAD00;
        nxt = done ? IDLE : RD_AH;
      end
      default: nxt = INIT_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_WAIT;
      int_sync <= 3'b000;
      timer <= 16'h0000;
      pl <= 8'h00;
      ph <= 8'h00;
      al <= 8'h00;
      wrt <= 1'b0;
      vld <= 1'b0;
      ptch_rt <= 16'sh0000;
      ptch_int <= 27'sh0000000;
    end else begin
      state <= nxt;
      int_sync <= {int_sync[1:0], INT};
      timer <= (state == INIT_WAIT) ? timer + 16'd1 : timer;
      // a command state is entered only from a different state, so this marks its first cycle
      wrt <= (nxt != state) && (nxt != IDLE) && (nxt != INIT_WAIT);
      vld <= upd;
      if (done && state == RD_PL) pl <= rd_data[7:0];
      if (done && state == RD_PH) ph <= rd_data[7:0];
      if (done && state == RD_AL) al <= rd_data[7:0];
      if (upd) begin
        ptch_rt <= rate_comp;
        ptch_int <= ptch_int - rate_ext + fusion;
      end
    end
  end
endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
- Producer side of the balance controller's inertial data interface.
- Sequences the IMU through an existing SPI master: a one-time config write burst after reset, then a 4-register read on every IMU data-ready interrupt.
- Compensates the pitch rate and fuses it with an accelerometer-derived pitch (complementary filter).
- Presents ptch, ptch_rt and a one-cycle vld strobe to the PID block.

Parameters:
- fast_sim, 1, 1: init wait terminal count 511 clocks (shortened for simulation). 0: terminal count 65535 clocks.
- PTCH_RT_OFFSET, 16'h0050, gyro pitch-rate zero offset, subtracted from the raw rate.
- AZ_OFFSET, 16'h00A0, accelerometer Z zero offset, subtracted from the raw AZ.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- INT  in  1  IMU data-ready, asynchronous to clk
- done  in  1  SPI master transaction complete, 1-cycle pulse
- rd_data  in  16  SPI master read data; only [7:0] used
- wrt  out  1  start SPI transaction, 1-cycle pulse
- cmd  out  16  SPI command word {addr/op[15:8], data[7:0]}
- ptch  out  16 signed  fused pitch
- ptch_rt  out  16 signed  compensated pitch rate
- vld  out  1  new ptch/ptch_rt sample, 1-cycle pulse

Behaviour:
- Reset values:
  - wrt=0, cmd=0, vld=0, ptch=0, ptch_rt=0.
  - Init timer, integrator and holding bytes = 0.
  - FSM = INIT_WAIT.
- INT handling: double-flopped into clk domain, then rising-edge detected. An edge is acted on only in IDLE; edges in any other state are dropped, not queued.
- FSM states: INIT_WAIT, CFG0-CFG3, IDLE, RD_PL, RD_PH, RD_AL, RD_AH.
- INIT_WAIT:
  - 16-bit timer increments every clock.
  - At terminal count (511 or 65535 per fast_sim) -> CFG0.
- Command states:
  - wrt=1 for exactly the first cycle in the state; cmd is held stable for the whole state.
  - The FSM stays in the state until done.
  - On done: capture rd_data[7:0] for read states, then advance.
  - Config/read commands: CFG0=0x0D02, CFG1=0x1053, CFG2=0x1150, CFG3=0x1460, RD_PL=0xA2xx, RD_PH=0xA3xx, RD_AL=0xACxx, RD_AH=0xADxx; xx=00.
- Transitions: CFG3 done -> IDLE. IDLE + INT edge -> RD_PL. RD_AH done -> IDLE.
- Sample assembly:
  - On RD_AH done, assert internal upd for 1 cycle.
  - rate_raw = {PH,PL}; az_raw = {AH,AL}.
- Arithmetic, registered on upd:
  - ptch_rt <= rate_raw - PTCH_RT_OFFSET (16-bit signed, wrap, no saturation).
  - az_comp = az_raw - AZ_OFFSET (16 signed).
  - prod = az_comp * 327 (25 bits signed).
  - ptch_acc = sign-extend(prod[24:13]) to 16 bits.
  - fusion = +1024 if ptch_acc > ptch (signed compare against the current ptch), else -1024.
  - ptch_int (27 bits signed) <= ptch_int - sext27(rate_raw - PTCH_RT_OFFSET) + fusion. The accumulator wraps; no overflow protection.
  - ptch = ptch_int[26:11], combinational from the register.
- vld: registered copy of upd. It is high in the same cycle that the new ptch/ptch_rt first appear.
- Latency: vld rises 1 clock after the done pulse of RD_AH.
- Mid-operation reset: asynchronous return to reset values. The full init sequence reruns; no partial SPI state is retained.
- done outside a command state, or a second done in the same state: ignored.

Test Plan:
- Reset, fast_sim=1, SPI model returns done 8 cycles after each wrt -> no wrt for 511 cycles. Then 4 wrt pulses, each 1 cycle wide, with cmd 0x0D02, 0x1053, 0x1150, 0x1460 in order. Each wrt occurs only after the prior done. FSM then idles with no further wrt.
- After init, INT rises; model returns PL=0x55, PH=0x00, AL=0xA0, AH=0x00 -> cmds 0xA200, 0xA300, 0xAC00, 0xAD00. vld pulses 1 cycle, one clock after the last done. ptch_rt=0x0005; ptch_acc=0; ptch_int=-5-1024=-1029; ptch=0xFFFF.
- Four INT samples with rate_raw=0x0050, az_raw=0x00A0:
  - Sample 1: ptch_int=-1024, ptch=-1.
  - Sample 2: ptch_int=0, ptch=0.
  - Samples 3-4: alternate -1, 0.
  - ptch_rt=0 throughout.
- Constant rate_raw=0x0850, az_raw=0x00A0:
  - After sample 1: ptch_int=-3072, ptch=-2.
  - After sample 2: ptch_int=-4096, ptch=-2.
  - ptch monotonically non-increasing over 20 samples; ptch_rt=0x0800.
- Extra INT rising edge during RD_PH, plus INT held high across IDLE -> exactly one read sequence and one vld per distinct edge seen in IDLE.
- rst_n asserted while in RD_AL -> wrt, vld, ptch, ptch_rt all 0 immediately. After release, the 511-cycle wait and the 4 config writes repeat before any read.
